sifive_scope_amba_prot_arbiter: RTL

//  Round-robin arbiter sharing one AMBA address-channel slot (addr + prot attributes) among N_REQ

---
 rtl/sifive_scope_amba_prot_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sifive_scope_amba_prot_arbiter.sv
// Round-robin arbiter feeding one registered AMBA address-channel slot.
// Each captured request has its prot attributes sanitised against per-requester permissions.
// Violations are recorded in sticky per-requester error bits for the debug path.
module sifive_scope_amba_prot_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*7-1:0]      req_prot,
  input  logic [N_REQ-1:0]        cfg_priv_en,
  input  logic [N_REQ-1:0]        cfg_sec_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [6:0]              out_prot,
  output logic [ID_W-1:0]         out_id,
  output logic [N_REQ-1:0]        err_sticky,
  input  logic [N_REQ-1:0]        err_clr
);

  localparam int unsigned PROT_W = 7;
  // prot packing: {fetch, secure, privileged, writealloc, readalloc, modifiable, bufferable}
  localparam int unsigned P_SEC  = 5;
  localparam int unsigned P_PRIV = 4;
  localparam int unsigned P_WA   = 3;
  localparam int unsigned P_RA   = 2;
  localparam int unsigned P_MOD  = 1;

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [PROT_W-1:0] out_prot_q, out_prot_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]  err_q, err_d;

  logic              slot_free;
  logic              any_valid;
  logic              hi_any;
  logic [ID_W-1:0]   hi_idx;
  logic [ID_W-1:0]   lo_idx;
  logic [ID_W-1:0]   grant_idx;
  logic              grant;
  logic [N_REQ-1:0]  grant_oh;
  logic [ADDR_W-1:0] sel_addr;
  logic [PROT_W-1:0] sel_prot;
  logic              sel_priv_ok;
  logic              sel_sec_ok;
  logic [PROT_W-1:0] san_prot;
  logic              san_viol;

  // Round-robin pick: lowest valid index at or above ptr, else lowest valid index overall
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_idx = ID_W'(i);
        if (ID_W'(i) >= ptr_q) begin
          hi_any = 1'b1;
          hi_idx = ID_W'(i);
        end
      end
    end
    any_valid = |req_valid;
    grant_idx = hi_any ? hi_idx : lo_idx;
    slot_free = !out_valid_q || out_ready;
    grant     = reset_n && slot_free && any_valid;
  end

  // Mux out the granted requester's payload and permissions
  always_comb begin
    grant_oh    = '0;
    sel_addr    = '0;
    sel_prot    = '0;
    sel_priv_ok = 1'b0;
    sel_sec_ok  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        grant_oh[i] = grant;
        sel_addr    = req_addr[i*ADDR_W +: ADDR_W];
        sel_prot    = req_prot[i*PROT_W +: PROT_W];
        sel_priv_ok = cfg_priv_en[i];
        sel_sec_ok  = cfg_sec_en[i];
      end
    end
    req_ready = grant_oh;
  end

  // Strip disallowed privilege/security bits and illegal allocate hints
  always_comb begin
    san_prot = sel_prot;
    san_viol = 1'b0;
    if (sel_prot[P_PRIV] && !sel_priv_ok) begin
      san_prot[P_PRIV] = 1'b0;
      san_viol         = 1'b1;
    end
    if (sel_prot[P_SEC] && !sel_sec_ok) begin
      san_prot[P_SEC] = 1'b0;
      san_viol        = 1'b1;
    end
    if (!sel_prot[P_MOD] && (sel_prot[P_RA] || sel_prot[P_WA])) begin
      san_prot[P_RA] = 1'b0;
      san_prot[P_WA] = 1'b0;
      san_viol       = 1'b1;
    end
  end

  // Next-state for slot, pointer and sticky errors; a new violation beats a clear
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_prot_d  = out_prot_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    err_d       = err_q & ~err_clr;
    if (grant) begin
      out_valid_d = 1'b1;
      out_addr_d  = sel_addr;
      out_prot_d  = san_prot;
      out_id_d    = grant_idx;
      ptr_d       = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      if (san_viol) begin
        err_d = err_d | grant_oh;
      end
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_prot_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
      err_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_prot_q  <= out_prot_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_prot   = out_prot_q;
  assign out_id     = out_id_q;
  assign err_sticky = err_q;

endmodule
